// File: rtl/irq_vec_gen.sv
// Multi-source interrupt vector generator: latches request edges into pending bits,
// arbitrates unmasked sources round-robin and drives one endpoint interrupt per grant.
module irq_vec_gen #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned HOLDOFF  = 4,
  parameter int unsigned VEC_BASE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic [NUM_SRC-1:0] irq_mask,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               irq_sent,
  output logic               cfg_interrupt_n,
  input  logic               cfg_interrupt_rdy_n,
  output logic [7:0]         cfg_interrupt_di
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_SRC - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] req_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               int_n_q, int_n_d;
  logic [7:0]         di_q, di_d;
  logic               sent_q, sent_d;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] edge_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  // Search begins one past the last winner and wraps; first eligible index wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SRC-1:0] el,
                                             input logic [IDX_W-1:0]   last);
    logic             found;
    logic [IDX_W-1:0] win;
    logic [31:0]      idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(last) + k) % NUM_SRC;
      if (!found && el[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
    return {found, win};
  endfunction

  assign elig     = pending_q & ~irq_mask;
  assign edge_vec = irq_req & ~req_prev_q;
  assign {pick_found, pick_idx} = rr_pick(elig, last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    int_n_d = int_n_q;
    di_d    = di_q;
    sent_d  = 1'b0;
    clr_vec = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          last_d  = pick_idx;
          di_d    = 8'(VEC_BASE + 32'(pick_idx));
          int_n_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The request is never withdrawn; only the acknowledge ends WAIT.
        if (!cfg_interrupt_rdy_n) begin
          int_n_d          = 1'b1;
          sent_d           = 1'b1;
          clr_vec[win_q]   = 1'b1;
          if (HOLDOFF == 0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = 16'(HOLDOFF);
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        int_n_d = 1'b1;
        if (cnt_q <= 16'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        int_n_d = 1'b1;
      end
    endcase
    // A fresh edge outranks the acknowledge-clear on the same bit.
    pending_d = (pending_q & ~clr_vec) | edge_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_prev_q <= '0;
      pending_q  <= '0;
      last_q     <= LAST_RST;
      win_q      <= '0;
      cnt_q      <= '0;
      int_n_q    <= 1'b1;
      di_q       <= '0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= irq_req;
      pending_q  <= pending_d;
      last_q     <= last_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      int_n_q    <= int_n_d;
      di_q       <= di_d;
      sent_q     <= sent_d;
    end
  end

  assign irq_pending      = pending_q;
  assign irq_sent         = sent_q;
  assign cfg_interrupt_n  = int_n_q;
  assign cfg_interrupt_di = di_q;

endmodule

// File: tb/tb_irq_vec_gen.sv
// Scoreboard bench for irq_vec_gen: two instances (hold-off 4 / vector base 0, and
// hold-off 0 / vector base 254) share stimulus; a behavioural model predicts every cycle.
module tb_irq_vec_gen;

  localparam int N    = 4;
  localparam int HO_A = 4;
  localparam int HO_B = 0;
  localparam int VB_A = 0;
  localparam int VB_B = 254;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] irq_req = '0;
  logic [3:0] irq_mask = '0;
  logic       rdy_n = 1'b1;

  logic [3:0] a_pend, b_pend;
  logic       a_sent, b_sent, a_intn, b_intn;
  logic [7:0] a_di, b_di;

  always #5 clk = ~clk;

  irq_vec_gen #(.NUM_SRC(N), .HOLDOFF(HO_A), .VEC_BASE(VB_A)) u_a (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_mask(irq_mask),
    .irq_pending(a_pend), .irq_sent(a_sent), .cfg_interrupt_n(a_intn),
    .cfg_interrupt_rdy_n(rdy_n), .cfg_interrupt_di(a_di));

  irq_vec_gen #(.NUM_SRC(N), .HOLDOFF(HO_B), .VEC_BASE(VB_B)) u_b (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_mask(irq_mask),
    .irq_pending(b_pend), .irq_sent(b_sent), .cfg_interrupt_n(b_intn),
    .cfg_interrupt_rdy_n(rdy_n), .cfg_interrupt_di(b_di));

  typedef struct {
    logic       intn;
    logic [7:0] di;
    logic [3:0] pend;
    logic       sent;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: one slot per instance. phase 0 = idle, 1 = interrupt outstanding,
  // 2 = gap after acknowledge with 'gap' cycles left.
  int         m_phase[2];
  int         m_gap[2];
  int         m_cur[2];
  int         m_last[2];
  logic [3:0] m_pend[2];
  logic [3:0] m_prev[2];
  logic       m_intn[2];
  logic [7:0] m_di[2];
  logic       m_sent[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_gap[d]   = 0;
      m_cur[d]   = 0;
      m_last[d]  = N - 1;
      m_pend[d]  = '0;
      m_prev[d]  = '0;
      m_intn[d]  = 1'b1;
      m_di[d]    = '0;
      m_sent[d]  = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic [3:0] mask,
                                     input logic rdyn);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] edges;
      logic [3:0] nxt;
      int         ho;
      int         vb;
      int         s;
      exp_t       e;
      ho        = (d == 0) ? HO_A : HO_B;
      vb        = (d == 0) ? VB_A : VB_B;
      edges     = req & ~m_prev[d];
      m_prev[d] = req;
      m_sent[d] = 1'b0;
      nxt       = m_pend[d];
      if (m_phase[d] == 0) begin
        for (int o = 1; o <= N; o++) begin
          s = (m_last[d] + o) % N;
          if (m_phase[d] == 0 && m_pend[d][s] && !mask[s]) begin
            m_phase[d] = 1;
            m_cur[d]   = s;
            m_last[d]  = s;
            m_di[d]    = 8'((vb + s) % 256);
            m_intn[d]  = 1'b0;
          end
        end
      end else if (m_phase[d] == 1) begin
        if (!rdyn) begin
          m_intn[d]      = 1'b1;
          m_sent[d]      = 1'b1;
          nxt[m_cur[d]]  = 1'b0;
          if (ho == 0) m_phase[d] = 0;
          else begin
            m_phase[d] = 2;
            m_gap[d]   = ho;
          end
        end
      end else begin
        m_gap[d] = m_gap[d] - 1;
        if (m_gap[d] == 0) m_phase[d] = 0;
      end
      m_pend[d] = nxt | edges;
      e.intn = m_intn[d];
      e.di   = m_di[d];
      e.pend = m_pend[d];
      e.sent = m_sent[d];
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endfunction

  // Called at a falling edge; inputs apply to the following rising edge.
  task automatic step(input logic [3:0] req, input logic [3:0] mask, input logic rdyn);
    irq_req  = req;
    irq_mask = mask;
    rdy_n    = rdyn;
    model_step(req, mask, rdyn);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] req, input logic [3:0] mask,
                     input logic rdyn);
    for (int i = 0; i < n; i++) step(req, mask, rdyn);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst A.int_n", 32'(a_intn), 32'(1'b1));
    chk("rst A.pending", 32'(a_pend), 32'(4'b0));
    chk("rst A.sent", 32'(a_sent), 32'(1'b0));
    chk("rst A.di", 32'(a_di), 32'(8'h00));
    chk("rst B.int_n", 32'(b_intn), 32'(1'b1));
    chk("rst B.pending", 32'(b_pend), 32'(4'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk($sformatf("A.int_n c%0d", cyc), 32'(a_intn), 32'(e.intn));
        chk($sformatf("A.di c%0d", cyc), 32'(a_di), 32'(e.di));
        chk($sformatf("A.pending c%0d", cyc), 32'(a_pend), 32'(e.pend));
        chk($sformatf("A.sent c%0d", cyc), 32'(a_sent), 32'(e.sent));
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk($sformatf("B.int_n c%0d", cyc), 32'(b_intn), 32'(e.intn));
        chk($sformatf("B.di c%0d", cyc), 32'(b_di), 32'(e.di));
        chk($sformatf("B.pending c%0d", cyc), 32'(b_pend), 32'(e.pend));
        chk($sformatf("B.sent c%0d", cyc), 32'(b_sent), 32'(e.sent));
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] m;
    int         guard;
    do_reset();

    // Single source, acknowledged three cycles after assertion.
    step(4'b0100, 4'b0, 1'b1);
    run(4, 4'b0, 4'b0, 1'b1);
    step(4'b0, 4'b0, 1'b0);
    run(10, 4'b0, 4'b0, 1'b1);

    // Round-robin across all sources, then sources 0 and 3 together.
    run(40, 4'b1111, 4'b0, 1'b0);
    run(2, 4'b0000, 4'b0, 1'b0);
    run(30, 4'b1001, 4'b0, 1'b0);
    run(10, 4'b0000, 4'b0, 1'b0);

    // Coalescing: extra pulses on source 1 while its first interrupt stalls.
    step(4'b0010, 4'b0, 1'b1);
    step(4'b0000, 4'b0, 1'b1);
    for (int i = 0; i < 18; i++)
      step((i == 4 || i == 8) ? 4'b0010 : 4'b0000, 4'b0, 1'b1);
    run(30, 4'b0, 4'b0, 1'b0);

    // Masked source stays pending, then fires once unmasked.
    step(4'b0001, 4'b0001, 1'b0);
    run(50, 4'b0, 4'b0001, 1'b0);
    run(12, 4'b0, 4'b0000, 1'b0);

    // New edge on source 1 in the very cycle its acknowledge is sampled.
    step(4'b0010, 4'b0, 1'b1);
    run(2, 4'b0000, 4'b0, 1'b1);
    step(4'b0010, 4'b0, 1'b0);
    run(20, 4'b0000, 4'b0, 1'b0);

    // Reset while an interrupt is outstanding.
    step(4'b0001, 4'b0, 1'b1);
    run(4, 4'b0, 4'b0, 1'b1);
    do_reset();
    run(10, 4'b0, 4'b0, 1'b0);

    // Randomized traffic with one mid-run reset.
    r = '0;
    m = '0;
    for (int i = 0; i < 3000; i++) begin
      r = r ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 49) == 0) m = 4'($urandom) & 4'($urandom);
      if (i == 1500) do_reset();
      step(r, m, ($urandom_range(0, 3) != 0));
    end
    run(60, 4'b0, 4'b0, 1'b0);

    guard = 0;
    while ((qa.size() + qb.size()) != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
